// File: rtl/cmem_cache_pkg.sv
// Shared types for the cmem_cache L1: line geometry, controller state, line typedefs.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package cache_types;

  localparam int ADDR_BITS   = 32;
  localparam int OFFSET_BITS = 5;
  localparam int LINE_BITS   = 256;
  localparam int LINE_BYTES  = LINE_BITS / 8;

  typedef enum logic [1:0] {
    CHECK     = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } cache_state_t;

  typedef logic [LINE_BITS-1:0]  line_t;
  typedef logic [LINE_BYTES-1:0] line_be_t;
  // Line number: {tag, index}. The tag is its upper (ADDR_BITS - OFFSET_BITS - S_INDEX) bits.
  typedef logic [ADDR_BITS-OFFSET_BITS-1:0] line_addr_t;

  // Byte address of the first byte of a line.
  function automatic logic [ADDR_BITS-1:0] line_base(input line_addr_t la);
    return {la, {OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/cmem_cache_array.sv
// Per-set valid/dirty/tag/data storage for the direct-mapped cache.
// Latency: combinational read of the indexed set; writes land at the next rising edge.
// Backpressure: none; the controller owns all sequencing.
module cache_array
  import cache_types::*;
#(
  parameter int S_INDEX  = 3,
  parameter int TAG_BITS = ADDR_BITS - OFFSET_BITS - S_INDEX
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [S_INDEX-1:0]  idx,
  output logic                rd_valid,
  output logic                rd_dirty,
  output logic [TAG_BITS-1:0] rd_tag,
  output line_t               rd_line,
  input  line_be_t            byte_we,
  input  line_t               line_wdata,
  input  logic                tag_we,
  input  logic [TAG_BITS-1:0] tag_wdata,
  input  logic                valid_set,
  input  logic                dirty_we,
  input  logic                dirty_wdata
);

  localparam int SETS = 1 << S_INDEX;

  logic [SETS-1:0]     valid_q;
  logic [SETS-1:0]     dirty_q;
  logic [TAG_BITS-1:0] tag_q  [SETS];
  line_t               data_q [SETS];

  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_line  = data_q[idx];

  // Valid/dirty are the only reset state; a cleared valid bit hides stale tags and data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (valid_set) valid_q[idx] <= 1'b1;
      if (dirty_we)  dirty_q[idx] <= dirty_wdata;
    end
  end

  // Tag update on line fill.
  always_ff @(posedge clk) begin
    if (tag_we) tag_q[idx] <= tag_wdata;
  end

  // Byte-lane data write: a full mask for fills, one word's lanes for CPU stores.
  always_ff @(posedge clk) begin
    for (int b = 0; b < LINE_BYTES; b++) begin
      if (byte_we[b]) data_q[idx][b*8 +: 8] <= line_wdata[b*8 +: 8];
    end
  end

endmodule

// File: rtl/cmem_cache.sv
// Direct-mapped write-back L1 serving one CPU cmem port, with 256-bit line fills/writebacks on pmem.
// Latency: hits respond in the request cycle; misses respond one cycle after the fill's pmem_resp.
// Backpressure: CPU holds its request until mem_resp; pmem requests are held stable until pmem_resp.
// Optional: define CMEM_CACHE_PERF_EN to add hit_count/miss_count outputs.
module cmem_cache
  import cache_types::*;
#(
  parameter int S_INDEX = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [3:0]   mem_byte_enable,
  input  logic [31:0]  mem_address,
  input  logic [31:0]  mem_wdata,
  output logic         mem_resp,
  output logic [31:0]  mem_rdata,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic         pmem_resp,
  input  logic [255:0] pmem_rdata
`ifdef CMEM_CACHE_PERF_EN
  ,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
`endif
);

  localparam int TAG_BITS = ADDR_BITS - OFFSET_BITS - S_INDEX;

  cache_state_t        state, next_state;
  logic [S_INDEX-1:0]  idx;
  logic [TAG_BITS-1:0] req_tag;
  logic [2:0]          word_sel;
  logic                req, hit;
  logic                arr_valid, arr_dirty;
  logic [TAG_BITS-1:0] arr_tag;
  line_t               arr_line;
  line_be_t            byte_we;
  line_t               line_wdata;
  logic                tag_we, valid_set, dirty_we, dirty_wdata;
  logic                unused_addr_lsbs;

  assign idx              = mem_address[OFFSET_BITS +: S_INDEX];
  assign req_tag          = mem_address[ADDR_BITS-1 -: TAG_BITS];
  assign word_sel         = mem_address[OFFSET_BITS-1:2];
  assign req              = mem_read | mem_write;
  assign hit              = arr_valid && (arr_tag == req_tag);
  assign unused_addr_lsbs = ^mem_address[1:0];

  cache_array #(
    .S_INDEX  (S_INDEX),
    .TAG_BITS (TAG_BITS)
  ) u_array (
    .clk         (clk),
    .rst_n       (rst_n),
    .idx         (idx),
    .rd_valid    (arr_valid),
    .rd_dirty    (arr_dirty),
    .rd_tag      (arr_tag),
    .rd_line     (arr_line),
    .byte_we     (byte_we),
    .line_wdata  (line_wdata),
    .tag_we      (tag_we),
    .tag_wdata   (req_tag),
    .valid_set   (valid_set),
    .dirty_we    (dirty_we),
    .dirty_wdata (dirty_wdata)
  );

  // Controller state register; reset aborts any miss in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= CHECK;
    else        state <= next_state;
  end

  // Next state, CPU/pmem outputs and array write controls. Outputs idle at zero.
  always_comb begin
    next_state   = state;
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    byte_we      = '0;
    line_wdata   = '0;
    tag_we       = 1'b0;
    valid_set    = 1'b0;
    dirty_we     = 1'b0;
    dirty_wdata  = 1'b0;
    unique case (state)
      CHECK: begin
        if (req) begin
          if (hit) begin
            mem_resp = 1'b1;
            // A write wins over a simultaneous read; an empty lane mask still marks the line dirty.
            if (mem_write) begin
              byte_we     = line_be_t'(mem_byte_enable) << {word_sel, 2'b00};
              line_wdata  = {8{mem_wdata}};
              dirty_we    = 1'b1;
              dirty_wdata = 1'b1;
            end else begin
              mem_rdata = arr_line[{word_sel, 5'b00000} +: 32];
            end
          end else if (arr_valid && arr_dirty) begin
            next_state = WRITEBACK;
          end else begin
            next_state = ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = line_base({arr_tag, idx});
        pmem_wdata   = arr_line;
        if (pmem_resp) begin
          dirty_we    = 1'b1;
          dirty_wdata = 1'b0;
          next_state  = ALLOCATE;
        end
      end
      ALLOCATE: begin
        pmem_read    = 1'b1;
        pmem_address = line_base({req_tag, idx});
        if (pmem_resp) begin
          byte_we     = '1;
          line_wdata  = pmem_rdata;
          tag_we      = 1'b1;
          valid_set   = 1'b1;
          dirty_we    = 1'b1;
          dirty_wdata = 1'b0;
          next_state  = CHECK;
        end
      end
      default: next_state = CHECK;
    endcase
  end

`ifdef CMEM_CACHE_PERF_EN
  logic fill_done_q;

  // Counts hits and misses; the response in the cycle right after a fill belongs to the miss.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_count   <= '0;
      miss_count  <= '0;
      fill_done_q <= 1'b0;
    end else begin
      fill_done_q <= (state == ALLOCATE) && pmem_resp;
      if (mem_resp && !fill_done_q)
        hit_count <= hit_count + 32'd1;
      if ((state == CHECK) && (next_state != CHECK))
        miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cmem_cache.sv
// Self-checking bench for cmem_cache: directed vector table, reset/withdraw corner cases,
// and randomized traffic against a flat-memory + resident-line reference model.
module tb_cmem_cache;

  logic         clk;
  logic         rst_n;
  logic         mem_read, mem_write;
  logic [3:0]   mem_byte_enable;
  logic [31:0]  mem_address, mem_wdata;
  logic         mem_resp;
  logic [31:0]  mem_rdata;
  logic         pmem_read, pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic         pmem_resp;
  logic [255:0] pmem_rdata;
`ifdef CMEM_CACHE_PERF_EN
  logic [31:0]  hit_count, miss_count;
`endif

  cmem_cache #(.S_INDEX(3)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_resp        (mem_resp),
    .mem_rdata       (mem_rdata),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_address    (pmem_address),
    .pmem_wdata      (pmem_wdata),
    .pmem_resp       (pmem_resp),
    .pmem_rdata      (pmem_rdata)
`ifdef CMEM_CACHE_PERF_EN
    ,
    .hit_count       (hit_count),
    .miss_count      (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Backing memory (what pmem holds) and golden CPU-visible memory, both word-addressed.
  bit [31:0] ram  [int unsigned];
  bit [31:0] gold [int unsigned];

  function automatic bit [31:0] init_word(input bit [31:0] a);
    return ({a[31:2], 2'b00} * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction
  function automatic bit [31:0] ram_rd(input bit [31:0] a);
    if (ram.exists(a >> 2)) return ram[a >> 2];
    return init_word(a);
  endfunction
  function automatic bit [31:0] gold_rd(input bit [31:0] a);
    if (gold.exists(a >> 2)) return gold[a >> 2];
    return init_word(a);
  endfunction

  // Reference model of which line each set holds (8 sets, line number = addr>>5).
  bit        m_valid [8];
  bit        m_dirty [8];
  bit [26:0] m_line  [8];
  int        exp_hits = 0;
  int        exp_misses = 0;

  // pmem responder state, observed by the op task.
  bit          hold_resp = 0;
  bit          wb_seen, fill_seen;
  logic [31:0] wb_addr, fill_addr;
  int unsigned fill_cyc;

  // pmem responder: random latency, checks request exclusivity/alignment/stability.
  initial begin
    bit          trk;
    logic [31:0] trk_addr;
    int          wait_cnt;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    trk        = 0;
    trk_addr   = '0;
    wait_cnt   = 0;
    forever begin
      @(negedge clk);
      if (pmem_resp) begin
        pmem_resp = 1'b0;
        trk       = 0;
        wait_cnt  = $urandom_range(0, 3);
      end else if (pmem_read || pmem_write) begin
        check("pmem_rd_wr_exclusive", {31'd0, pmem_read && pmem_write}, 32'd0);
        check("pmem_addr_aligned", {27'd0, pmem_address[4:0]}, 32'd0);
        if (trk) check("pmem_addr_stable", pmem_address, trk_addr);
        trk      = 1;
        trk_addr = pmem_address;
        if (!hold_resp) begin
          if (wait_cnt > 0) begin
            wait_cnt--;
          end else begin
            if (pmem_write) begin
              wb_seen = 1;
              wb_addr = pmem_address;
              for (int w = 0; w < 8; w++) begin
                check("wb_data", pmem_wdata[w*32 +: 32], gold_rd(pmem_address + 32'(w*4)));
                ram[(pmem_address + 32'(w*4)) >> 2] = pmem_wdata[w*32 +: 32];
              end
            end else begin
              fill_seen = 1;
              fill_addr = pmem_address;
              fill_cyc  = cyc;
              for (int w = 0; w < 8; w++)
                pmem_rdata[w*32 +: 32] = ram_rd(pmem_address + 32'(w*4));
            end
            pmem_resp = 1'b1;
          end
        end
      end else begin
        trk = 0;
      end
    end
  end

  bit [31:0] last_rdata;
  bit        last_hit, last_wb;

  // One CPU request held until mem_resp, checked against the reference model. Starts after posedge.
  task automatic run_op(input bit rd, input bit wr, input bit [31:0] addr,
                        input bit [31:0] wdata, input bit [3:0] be);
    int          s;
    bit [26:0]   la;
    bit          exp_hit, exp_wb, got;
    bit [31:0]   exp_wb_addr, exp_rd, g;
    int          n;
    int unsigned resp_cyc;
    s           = int'(addr[7:5]);
    la          = addr[31:5];
    exp_hit     = m_valid[s] && (m_line[s] == la);
    exp_wb      = !exp_hit && m_valid[s] && m_dirty[s];
    exp_wb_addr = {m_line[s], 5'b00000};
    exp_rd      = gold_rd(addr);
    n           = 0;
    got         = 0;
    resp_cyc    = 0;
    wb_seen     = 0;
    fill_seen   = 0;
    mem_read = rd; mem_write = wr; mem_address = addr; mem_wdata = wdata; mem_byte_enable = be;
    while (!got && n < 100) begin
      @(negedge clk);
      if (mem_resp) begin
        got        = 1;
        last_rdata = mem_rdata;
        resp_cyc   = cyc;
      end else begin
        n++;
      end
      @(posedge clk); #1;
    end
    mem_read = 0; mem_write = 0;
    check("resp_seen", {31'd0, got}, 32'd1);
    last_hit = got && (n == 0);
    last_wb  = wb_seen;
    check("hit_zero_wait", {31'd0, last_hit}, {31'd0, exp_hit});
    check("writeback_issued", {31'd0, wb_seen}, {31'd0, exp_wb});
    if (exp_wb) check("wb_addr", wb_addr, exp_wb_addr);
    if (!exp_hit) begin
      check("fill_addr", fill_addr, {la, 5'b00000});
      check("miss_resp_latency", resp_cyc, fill_cyc + 1);
    end else begin
      check("hit_no_fill", {31'd0, fill_seen}, 32'd0);
    end
    if (!wr) check("rdata", last_rdata, exp_rd);
    if (!exp_hit) begin
      m_valid[s] = 1; m_line[s] = la; m_dirty[s] = 0;
      exp_misses++;
    end else begin
      exp_hits++;
    end
    if (wr) begin
      g = gold_rd(addr);
      for (int b = 0; b < 4; b++) if (be[b]) g[b*8 +: 8] = wdata[b*8 +: 8];
      gold[addr >> 2] = g;
      m_dirty[s] = 1;
    end
  endtask

  typedef struct {
    bit        wr;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit [3:0]  be;
    bit        exp_hit;
    bit        exp_wb;
    bit [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int n;
    mem_read = 0; mem_write = 0; mem_byte_enable = 0; mem_address = 0; mem_wdata = 0;
    rst_n = 0;
    ram[32'h48 >> 2] = 32'hDEAD_BEEF; gold[32'h48 >> 2] = 32'hDEAD_BEEF;
    ram[32'h44 >> 2] = 32'hAAAA_AAAA; gold[32'h44 >> 2] = 32'hAAAA_AAAA;
    for (int i = 0; i < 8; i++) begin m_valid[i] = 0; m_dirty[i] = 0; m_line[i] = '0; end

    //          wr  addr          wdata          be       hit wb  rdata
    vecs[0] = '{1'b0, 32'h0000_0048, 32'h0,         4'b0000, 1'b0, 1'b0, 32'hDEAD_BEEF};
    vecs[1] = '{1'b0, 32'h0000_0048, 32'h0,         4'b0000, 1'b1, 1'b0, 32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 32'h0000_0044, 32'h1234_5678, 4'b0011, 1'b1, 1'b0, 32'h0};
    vecs[3] = '{1'b0, 32'h0000_0044, 32'h0,         4'b0000, 1'b1, 1'b0, 32'hAAAA_5678};
    vecs[4] = '{1'b0, 32'h0000_0140, 32'h0,         4'b0000, 1'b0, 1'b1, init_word(32'h140)};

    // Reset state
    @(posedge clk);
    @(negedge clk);
    check("rst_mem_resp", {31'd0, mem_resp}, 32'd0);
    check("rst_pmem_read", {31'd0, pmem_read}, 32'd0);
    check("rst_pmem_write", {31'd0, pmem_write}, 32'd0);
`ifdef CMEM_CACHE_PERF_EN
    check("rst_hit_count", hit_count, 32'd0);
    check("rst_miss_count", miss_count, 32'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1;

    // Directed vector table
    for (int i = 0; i < 5; i++) begin
      run_op(!vecs[i].wr, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be);
      check($sformatf("vec%0d_hit", i), {31'd0, last_hit}, {31'd0, vecs[i].exp_hit});
      check($sformatf("vec%0d_wb", i), {31'd0, last_wb}, {31'd0, vecs[i].exp_wb});
      if (!vecs[i].wr) check($sformatf("vec%0d_rdata", i), last_rdata, vecs[i].exp_rdata);
    end
    check("wb_addr_0x40", wb_addr, 32'h0000_0040);
    check("wb_merged_word", ram_rd(32'h44), 32'hAAAA_5678);
`ifdef CMEM_CACHE_PERF_EN
    check("perf_hits_directed", hit_count, 32'd3);
    check("perf_misses_directed", miss_count, 32'd2);
`endif

    // Reset during ALLOCATE: request must drop the cycle after reset is sampled
    hold_resp = 1;
    mem_read = 1; mem_address = 32'h48;
    n = 0;
    do begin @(negedge clk); n++; end while (!pmem_read && n < 20);
    check("rst_mid_alloc_started", {31'd0, pmem_read}, 32'd1);
    check("rst_mid_alloc_addr", pmem_address, 32'h0000_0040);
    @(posedge clk); #1;
    rst_n = 0; mem_read = 0;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_pmem_read", {31'd0, pmem_read}, 32'd0);
    check("rst_mid_pmem_write", {31'd0, pmem_write}, 32'd0);
    check("rst_mid_mem_resp", {31'd0, mem_resp}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1; hold_resp = 0;
    for (int i = 0; i < 8; i++) begin m_valid[i] = 0; m_dirty[i] = 0; end
    exp_hits = 0; exp_misses = 0;
    run_op(1, 0, 32'h48, 32'h0, 4'h0);
    check("reread_after_rst_misses", {31'd0, last_hit}, 32'd0);
`ifdef CMEM_CACHE_PERF_EN
    check("perf_after_rst_hits", hit_count, 32'd0);
    check("perf_after_rst_misses", miss_count, 32'd1);
`endif

    // Request withdrawn mid-miss: fill completes, no response
    hold_resp = 1; wb_seen = 0; fill_seen = 0;
    mem_read = 1; mem_address = 32'h60;
    n = 0;
    do begin @(negedge clk); n++; end while (!pmem_read && n < 20);
    check("withdraw_alloc_started", {31'd0, pmem_read}, 32'd1);
    @(posedge clk); #1;
    mem_read = 0; hold_resp = 0;
    n = 0;
    while (!fill_seen && n < 20) begin
      @(negedge clk);
      check("withdraw_no_resp", {31'd0, mem_resp}, 32'd0);
      n++;
    end
    check("withdraw_fill_done", {31'd0, fill_seen}, 32'd1);
    repeat (3) begin
      @(negedge clk);
      check("withdraw_no_resp_after", {31'd0, mem_resp}, 32'd0);
    end
    m_valid[3] = 1; m_line[3] = 27'(32'h60 >> 5); m_dirty[3] = 0; exp_misses++;
    @(posedge clk); #1;
    run_op(1, 0, 32'h60, 32'h0, 4'h0);
    check("withdraw_line_resident", {31'd0, last_hit}, 32'd1);

    // Empty byte mask: responds, data unchanged, line dirtied
    run_op(0, 1, 32'h48, 32'hFFFF_FFFF, 4'b0000);
    check("be0_hit", {31'd0, last_hit}, 32'd1);
    run_op(1, 0, 32'h148, 32'h0, 4'h0);
    check("be0_dirty_writeback", {31'd0, last_wb}, 32'd1);
    check("be0_data_unchanged", ram_rd(32'h48), 32'hDEAD_BEEF);

    // Read and write together behave as a write
    run_op(1, 1, 32'h14C, 32'h1122_3344, 4'b1111);
    run_op(1, 0, 32'h14C, 32'h0, 4'h0);
    check("rd_wr_as_write", last_rdata, 32'h1122_3344);

    // Randomized traffic over 4 tags x 8 sets
    for (int i = 0; i < 400; i++) begin
      bit [31:0] a, d;
      int        op;
      a  = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 5) |
           (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      d  = $urandom;
      op = $urandom_range(0, 2);
      run_op(op != 1, op != 0, a, d, 4'($urandom_range(0, 15)));
    end
`ifdef CMEM_CACHE_PERF_EN
    check("perf_final_hits", hit_count, 32'(exp_hits));
    check("perf_final_misses", miss_count, 32'(exp_misses));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cmem_cache.md
# cmem_cache

Direct-mapped, write-back L1 cache that is the responder on one `cmem_*` port of the pipelined CPU: it answers the CPU's held read/write requests with a single-cycle `mem_resp` pulse and initiates 256-bit line transfers on a `pmem_*` port toward the arbiter/physical memory. One instance serves the instruction port (a), another the data port (b). Hits complete with zero wait states so the pipeline keeps running; misses stall it until the line is filled.

## Interface
- `S_INDEX`, 3: index bits; 2**S_INDEX sets (default 8). Offset fixed at 5 bits (32-byte line); tag width = 27 − S_INDEX.
- `clk` in 1: sole clock, all state on rising edge.
- `rst_n` in 1: reset; synchronous, active-low.
- `mem_read` in 1: CPU read request, held until `mem_resp`.
- `mem_write` in 1: CPU write request, held until `mem_resp`.
- `mem_byte_enable` in 4: byte lane mask for writes.
- `mem_address` in 32: byte address; bits [1:0] ignored.
- `mem_wdata` in 32: write data.
- `mem_resp` out 1: one-cycle completion pulse.
- `mem_rdata` out 32: read word, valid while `mem_resp`=1.
- `pmem_read` out 1: line fill request, held until `pmem_resp`.
- `pmem_write` out 1: line writeback request, held until `pmem_resp`.
- `pmem_address` out 32: line-aligned address ([4:0]=0).
- `pmem_wdata` out 256: victim line.
- `pmem_resp` in 1: pmem completion pulse.
- `pmem_rdata` in 256: fill line, valid with `pmem_resp`.

## Operation
- FSM states: CHECK, WRITEBACK, ALLOCATE. Reset state CHECK.
- CHECK, no request: idle, all outputs 0.
- CHECK, request, hit (valid && tag match): `mem_resp`=1 combinationally same cycle; read returns word [4:2] of line; write merges `mem_wdata` per byte lane at the clock edge and sets dirty. Stay in CHECK.
- CHECK, request, miss, dirty victim: → WRITEBACK. Clean/invalid victim: → ALLOCATE.
- WRITEBACK: `pmem_write`=1, `pmem_address`={victim tag, index, 5'b0}, `pmem_wdata`=victim line; on `pmem_resp` clear dirty, → ALLOCATE.
- ALLOCATE: `pmem_read`=1, `pmem_address`={req tag, index, 5'b0}; on `pmem_resp` write line, tag, valid=1, dirty=0, → CHECK (hit resolves next cycle).
- `mem_read` and `mem_write` both high: treated as write.
- Write with `mem_byte_enable`=0000: responds, data unchanged, dirty set.
- Request withdrawn mid-miss (contract violation): fill completes, no `mem_resp`.
- `pmem_read` and `pmem_write` never both high.

## Timing
- Reset: state CHECK, all valid/dirty bits 0, `mem_resp`/`pmem_read`/`pmem_write`=0; tag/data arrays not reset. Reset mid-miss aborts; pmem request drops in the cycle after reset is sampled.
- Hit latency: 0 wait states (resp in request cycle).
- Clean miss: resp one cycle after `pmem_resp` of fill.
- Dirty miss: writeback, then fill, then CHECK; resp one cycle after fill `pmem_resp`.
- `mem_resp` never held more than one cycle for one request; after a hit the next request is evaluated the following cycle.
- pmem requests asserted from the cycle after the miss is detected and held stable until `pmem_resp`.

## Configuration
- `CMEM_CACHE_PERF_EN` defined: adds outputs `hit_count` out 32 and `miss_count` out 32; hit_count increments on every `mem_resp` not preceded by a fill for that request, miss_count on every CHECK→WRITEBACK/ALLOCATE transition; both reset to 0, wrap at 2**32.
- Undefined: ports and counters absent; functional behaviour identical.

## Structure
- Package `cache_types`: OFFSET_BITS=5, LINE_BITS=256, state enum `cache_state_t`, line/tag typedefs.
- Sub-module `cache_array`: per-set valid, dirty, tag, data storage; combinational read, synchronous write with 32-byte line write-enable mask; valid/dirty reset. FSM and datapath muxing in `cmem_cache`.

## Test plan
- Read 0x0000_0040 after reset → ALLOCATE with `pmem_address`=0x0000_0040; `pmem_rdata` word2=0xDEAD_BEEF; read 0x48 → `mem_rdata`=0xDEAD_BEEF one cycle after `pmem_resp`, `pmem_write` never asserted.
- Repeat read 0x48 → `mem_resp` same cycle, no pmem activity.
- Write 0x1234_5678 mask 0011 to 0x44 (old 0xAAAA_AAAA) → read 0x44 returns 0xAAAA_5678, line dirty.
- Read conflicting 0x0000_0140 (same index 2, S_INDEX=3) → WRITEBACK to 0x40 with modified word, then ALLOCATE 0x140, then resp.
- `rst_n`=0 during ALLOCATE → next cycle `pmem_read`=0, state CHECK; re-read 0x48 misses.
- With `CMEM_CACHE_PERF_EN`: after above sequence `hit_count`/`miss_count` match scoreboard (e.g. 3 hits / 2 misses before reset).
